not_not_judge: RTL and testbench

- Player-side counterpart of the Not-Not puzzle generator.
- Requests a puzzle and latches the generator's 4-bit expected answer mask.
- Times the player, compares the submitted switch pattern, and keeps score and lives.
- Sits between the generator (whose enable it drives via next_puzzle) and the board I/O (SW answer, KEY submit, HEX/LEDR status).

---
 rtl/not_not_judge_pkg.sv | 32 +++
 rtl/not_not_round_timer.sv | 45 ++++
 rtl/not_not_judge.sv | 169 ++++++++++++++++
 tb/tb_not_not_judge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/not_not_judge_pkg.sv
// Shared definitions for the Not-Not player-side judge.
// Holds the FSM state encoding, round result codes and widths.
package not_not_pkg;

  // Width of the answer / expected mask.
  localparam int ANS_W = 4;

  // The answer window is split into this many slices.
  localparam int SLICES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT_VALID,
    ST_ANSWER,
    ST_RESULT,
    ST_OVER
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE    = 2'b00,
    RES_CORRECT = 2'b01,
    RES_WRONG   = 2'b10,
    RES_TIMEOUT = 2'b11
  } result_t;

  // Counter width able to hold n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/not_not_round_timer.sv
// Answer-window timer: 16 slices of SLICE_CYCLES cycles each.
// Ports: clock, reset, load (arm window), run (count),
//        time_left (slices remaining), timeout (window expired pulse).
module not_not_round_timer
  import not_not_pkg::*;
#(
  parameter int SLICE_CYCLES = 9_375_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  output logic [3:0] time_left,
  output logic       timeout
);

  localparam int CW = cnt_w(SLICE_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(SLICE_CYCLES - 1);

  logic [CW-1:0] slice_cnt;
  logic          slice_end;

  assign slice_end = (slice_cnt == '0);

  // Last cycle of the last slice: window is exhausted.
  assign timeout = run && slice_end && (time_left == 4'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slice_cnt <= '0;
      time_left <= 4'd0;
    end else if (load) begin
      slice_cnt <= RELOAD;
      time_left <= 4'(SLICES - 1);
    end else if (run) begin
      if (!slice_end) begin
        slice_cnt <= slice_cnt - 1'b1;
      end else if (time_left != 4'd0) begin
        time_left <= time_left - 4'd1;
        slice_cnt <= RELOAD;
      end
    end
  end

endmodule

// File: rtl/not_not_judge.sv
// Not-Not judge: requests puzzles, times and grades the player.
// Ports: clock, reset, start, puzzle_valid, expected, answer, submit
//        -> next_puzzle, score, lives, round_result, time_left, game_over.
module not_not_judge
  import not_not_pkg::*;
#(
  parameter int SLICE_CYCLES  = 9_375_000,
  parameter int RESULT_CYCLES = 50_000_000,
  parameter int LIVES         = 3,
  parameter int SCORE_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   puzzle_valid,
  input  logic [ANS_W-1:0]       expected,
  input  logic [ANS_W-1:0]       answer,
  input  logic                   submit,
  output logic                   next_puzzle,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [1:0]             lives,
  output logic [1:0]             round_result,
  output logic [3:0]             time_left,
  output logic                   game_over
);

  localparam int RW = cnt_w(RESULT_CYCLES);
  localparam logic [RW-1:0] RES_RELOAD = RW'(RESULT_CYCLES - 1);

  state_t state;
  state_t state_next;

  logic             start_q;
  logic             submit_q;
  logic             start_edge;
  logic             submit_edge;
  logic [ANS_W-1:0] exp_q;
  logic [RW-1:0]    res_cnt;
  logic             res_done;
  logic             timer_load;
  logic             timer_run;
  logic [3:0]       timer_left;
  logic             timeout;
  logic             correct;

  // Edge detectors run in every state so a level already
  // high on state entry never looks like a fresh press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_q  <= 1'b0;
      submit_q <= 1'b0;
    end else begin
      start_q  <= start;
      submit_q <= submit;
    end
  end

  assign start_edge  = start & ~start_q;
  assign submit_edge = submit & ~submit_q;
  assign correct     = (answer == exp_q);
  assign res_done    = (res_cnt == '0);

  // Stop the timer on a submission so time_left freezes at
  // the value shown when the player pressed, and so a
  // same-cycle timeout can never win over the submission.
  assign timer_load = (state == ST_WAIT_VALID) && puzzle_valid;
  assign timer_run  = (state == ST_ANSWER) && !submit_edge;

  not_not_round_timer #(
    .SLICE_CYCLES(SLICE_CYCLES)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .run      (timer_run),
    .time_left(timer_left),
    .timeout  (timeout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_OVER: begin
        if (start_edge) state_next = ST_REQUEST;
      end
      ST_REQUEST: begin
        state_next = ST_WAIT_VALID;
      end
      ST_WAIT_VALID: begin
        if (puzzle_valid) state_next = ST_ANSWER;
      end
      ST_ANSWER: begin
        if (submit_edge || timeout) begin
          state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_done) begin
          state_next = (lives == 2'd0) ?
                       ST_OVER : ST_REQUEST;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    next_puzzle = (state == ST_REQUEST);
    game_over   = (state == ST_OVER);
    time_left   = 4'd0;
    if (state == ST_ANSWER || state == ST_RESULT) begin
      time_left = timer_left;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      score        <= '0;
      lives        <= 2'd0;
      round_result <= RES_NONE;
      exp_q        <= '0;
      res_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_edge) begin
            score        <= '0;
            lives        <= 2'(LIVES);
            round_result <= RES_NONE;
          end
        end
        ST_WAIT_VALID: begin
          if (puzzle_valid) begin
            exp_q        <= expected;
            round_result <= RES_NONE;
          end
        end
        ST_ANSWER: begin
          res_cnt <= RES_RELOAD;
          if (submit_edge) begin
            if (correct) begin
              round_result <= RES_CORRECT;
              if (score != '1) score <= score + 1'b1;
            end else begin
              round_result <= RES_WRONG;
              if (lives != 2'd0) lives <= lives - 2'd1;
            end
          end else if (timeout) begin
            round_result <= RES_TIMEOUT;
            if (lives != 2'd0) lives <= lives - 2'd1;
          end
        end
        ST_RESULT: begin
          if (!res_done) res_cnt <= res_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_not_not_judge.sv
// Bench for not_not_judge: directed scenarios plus random play,
// all outputs compared every cycle against a phase-level model.
module tb_not_not_judge;

  localparam int S   = 4;
  localparam int R   = 3;
  localparam int L   = 3;
  localparam int SW  = 2;
  localparam int WIN = 16 * S;
  localparam int SMAX = (1 << SW) - 1;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_WAIT = 2;
  localparam int P_ANS  = 3;
  localparam int P_RES  = 4;
  localparam int P_OVER = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          puzzle_valid;
  logic          submit;
  logic [3:0]    expected;
  logic [3:0]    answer;
  logic          next_puzzle;
  logic [SW-1:0] score;
  logic [1:0]    lives;
  logic [1:0]    round_result;
  logic [3:0]    time_left;
  logic          game_over;

  always #5 clock = ~clock;

  not_not_judge #(
    .SLICE_CYCLES (S),
    .RESULT_CYCLES(R),
    .LIVES        (L),
    .SCORE_WIDTH  (SW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .puzzle_valid(puzzle_valid),
    .expected    (expected),
    .answer      (answer),
    .submit      (submit),
    .next_puzzle (next_puzzle),
    .score       (score),
    .lives       (lives),
    .round_result(round_result),
    .time_left   (time_left),
    .game_over   (game_over)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got,
                       input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, want);
  endtask

  // Model: game phase, cycles spent in the answer window,
  // cycles spent showing the result, and game bookkeeping.
  int m_ph, m_el, m_rc, m_tlf, m_exp;
  int m_score, m_lives, m_res;
  bit m_sq, m_bq;

  function automatic int m_tl();
    if (m_ph == P_ANS) return 15 - m_el / S;
    if (m_ph == P_RES) return m_tlf;
    return 0;
  endfunction

  task automatic m_reset();
    m_ph = P_IDLE; m_el = 0; m_rc = 0; m_tlf = 0;
    m_exp = 0; m_score = 0; m_lives = 0; m_res = 0;
    m_sq = 0; m_bq = 0;
  endtask

  task automatic m_step();
    bit se, be;
    se = start && !m_sq;
    be = submit && !m_bq;
    case (m_ph)
      P_IDLE, P_OVER: if (se) begin
        m_score = 0; m_lives = L; m_res = 0; m_ph = P_REQ;
      end
      P_REQ: m_ph = P_WAIT;
      P_WAIT: if (puzzle_valid) begin
        m_exp = int'(expected); m_el = 0; m_res = 0;
        m_ph = P_ANS;
      end
      P_ANS: begin
        if (be) begin
          m_tlf = m_tl();
          if (int'(answer) == m_exp) begin
            m_res = 1;
            if (m_score < SMAX) m_score++;
          end else begin
            m_res = 2; m_lives--;
          end
          m_rc = 0; m_ph = P_RES;
        end else if (m_el == WIN - 1) begin
          m_tlf = 0; m_res = 3; m_lives--;
          m_rc = 0; m_ph = P_RES;
        end else begin
          m_el++;
        end
      end
      P_RES: begin
        m_rc++;
        if (m_rc == R) m_ph = (m_lives == 0) ? P_OVER : P_REQ;
      end
      default: ;
    endcase
    m_sq = start;
    m_bq = submit;
  endtask

  task automatic check_outputs();
    check("next_puzzle", next_puzzle, int'(m_ph == P_REQ));
    check("game_over", game_over, int'(m_ph == P_OVER));
    check("score", score, m_score);
    check("lives", lives, m_lives);
    check("round_result", round_result, m_res);
    check("time_left", time_left, m_tl());
  endtask

  // One clock: drive at negedge, step model, compare next negedge.
  task automatic cyc(input logic st, input logic sb,
                     input logic pv, input logic [3:0] e,
                     input logic [3:0] a);
    start = st; submit = sb; puzzle_valid = pv;
    expected = e; answer = a;
    m_step();
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic do_reset();
    start = 0; submit = 0; puzzle_valid = 0;
    expected = 0; answer = 0;
    reset = 1;
    #1;
    m_reset();
    check_outputs();
    @(posedge clock);
    @(negedge clock);
    reset = 0;
  endtask

  task automatic go_to(input int ph);
    int n = 0;
    while (m_ph != ph && n < 200) begin
      cyc(0, 0, 0, 0, 0);
      n++;
    end
    check("phase_reached", m_ph, ph);
  endtask

  task automatic round(input logic [3:0] e, input logic [3:0] a,
                       input int dly);
    go_to(P_WAIT);
    cyc(0, 0, 1, e, 0);
    repeat (dly) cyc(0, 0, 0, 4'($urandom), 0);
    cyc(0, 1, 0, 0, a);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    reset = 1; start = 0; submit = 0; puzzle_valid = 0;
    expected = 0; answer = 0;
    m_reset();
    @(negedge clock);
    check_outputs();
    @(negedge clock);
    reset = 0;

    cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    check("idle_np", next_puzzle, 0);
    check("idle_score", score, 0);

    cyc(1, 0, 0, 0, 0);
    check("np_on", next_puzzle, 1);
    cyc(1, 0, 0, 0, 0);
    check("np_off", next_puzzle, 0);

    round(4'b0110, 4'b0110, 2);
    check("c1_result", round_result, 1);
    check("c1_score", score, 1);
    check("c1_lives", lives, 3);
    cyc(0, 0, 0, 0, 0);
    check("c1_np_wait", next_puzzle, 0);
    cyc(0, 0, 0, 0, 0);
    check("c1_np_next", next_puzzle, 1);

    for (int k = 0; k < 3; k++) begin
      logic [3:0] e;
      e = 4'($urandom);
      round(e, e, $urandom_range(0, 20));
    end
    check("score_sat", score, 3);

    round(4'b1001, 4'b1000, 1);
    check("wrong_result", round_result, 2);
    check("wrong_lives", lives, 2);
    check("wrong_score", score, 3);

    go_to(P_WAIT);
    cyc(0, 0, 1, 4'd5, 0);
    for (int i = 0; i < WIN; i++) begin
      check("tl_step", time_left, 15 - i / S);
      check("no_early_timeout", round_result, 0);
      cyc(0, 0, 0, 0, 0);
    end
    check("timeout_result", round_result, 3);
    check("timeout_lives", lives, 1);

    go_to(P_WAIT);
    cyc(0, 0, 1, 4'd5, 0);
    repeat (WIN - 1) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 4'd5);
    check("race_result", round_result, 1);
    check("race_lives", lives, 1);

    go_to(P_REQ);
    cyc(1, 0, 0, 0, 0);
    check("early_start_np", next_puzzle, 0);

    round(4'b1001, 4'b1000, 0);
    go_to(P_OVER);
    check("over_flag", game_over, 1);
    check("over_lives", lives, 0);

    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("restart_np", next_puzzle, 1);
    check("restart_score", score, 0);
    check("restart_lives", lives, 3);
    check("restart_over", game_over, 0);

    for (int k = 0; k < 3; k++) begin
      round(4'b1001, 4'b1000, k);
      check("gameover_lives", lives, 2 - k);
    end
    go_to(P_OVER);
    repeat (6) cyc(0, 0, 0, 0, 0);
    check("over_no_np", next_puzzle, 0);
    check("over_hold", game_over, 1);

    cyc(1, 0, 0, 0, 0);
    go_to(P_WAIT);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 4'd3, 0);
    repeat (5) cyc(0, 1, 0, 0, 4'd3);
    check("held_submit", round_result, 0);
    cyc(0, 0, 0, 0, 4'd3);
    cyc(0, 1, 0, 0, 4'd3);
    check("repress_result", round_result, 1);

    go_to(P_WAIT);
    cyc(0, 0, 1, 4'd7, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    do_reset();
    check("rst_time_left", time_left, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("post_rst_np", next_puzzle, 1);
    round(4'd7, 4'd7, 3);
    check("post_rst_result", round_result, 1);
    check("post_rst_score", score, 1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        logic st, sb, pv;
        logic [3:0] e, a;
        int sp;
        sp = ((i / 500) % 2 == 1) ? 80 : 3;
        st = ($urandom_range(0, 15) == 0) ? ~start : start;
        sb = ($urandom_range(0, sp) == 0) ? ~submit : submit;
        pv = 1'($urandom_range(0, 1));
        e  = 4'($urandom);
        a  = ($urandom_range(0, 1) == 1) ?
             4'(m_exp) : 4'($urandom);
        cyc(st, sb, pv, e, a);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
